z5xp1_inverse_seq: RTL and testbench

// Sequential inverse of the combinational z = 5*x + 1 map: accepts a ZW-bit code z,

---
 rtl/z5xp1_inverse_seq.sv | 140 ++++++++++++++
 tb/tb_z5xp1_inverse_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z5xp1_inverse_seq.sv
// z5xp1_inverse_seq: sequential decoder for the z = MUL*x + ADD code.
// Recovers x = (z - ADD) / MUL with a restoring divider that produces one
// quotient bit per cycle, MSB first. Codes that have no preimage are flagged:
// err_range means z < ADD or x does not fit in XW bits. err_mod means z - ADD
// is not a multiple of MUL. Both sides use valid/ready. The block takes one
// code at a time.
module z5xp1_inverse_seq #(
  parameter int XW  = 7,
  parameter int ZW  = 10,
  parameter int MUL = 5,
  parameter int ADD = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [ZW-1:0] z_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] x_o,
  output logic          err_mod,
  output logic          err_range
);

  // The remainder never reaches MUL. One extra bit holds the trial value
  // before the subtract step.
  localparam int RW = $clog2(MUL) + 1;
  localparam int CW = (ZW > 1) ? $clog2(ZW) : 1;
  localparam logic [RW:0]   MUL_T  = (RW + 1)'(MUL);
  localparam logic [ZW:0]   ADD_W  = (ZW + 1)'(ADD);
  localparam logic [CW-1:0] CNT_TOP = CW'(ZW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ZW-1:0] z_q;       // code captured at the accept edge
  logic [ZW-1:0] d;         // dividend z - ADD (low ZW bits)
  logic          under;     // borrow out of z - ADD: z < ADD
  logic [RW-1:0] rem;       // running remainder
  logic [ZW-1:0] q;         // quotient under construction
  logic [CW-1:0] cnt;       // index of the dividend bit being consumed
  logic          div_last;  // cnt==0 step done; flags are resolved next cycle

  logic [ZW:0]   diff;
  logic [RW:0]   trial;
  logic [RW:0]   trial_sub;
  logic          trial_ge;
  logic [RW-1:0] rem_nxt;
  logic          range_flag;
  logic          mod_flag;

  // Subtract the offset with one extra bit so that the borrow shows z < ADD.
  assign diff = {1'b0, z_q} - ADD_W;

  // One restoring-division step: shift in the next dividend bit, then subtract if it fits.
  assign trial     = {rem, d[cnt]};
  assign trial_ge  = (trial >= MUL_T);
  assign trial_sub = trial - MUL_T;
  assign rem_nxt   = trial_ge ? trial_sub[RW-1:0] : trial[RW-1:0];

  // Error classification from the finished quotient and remainder.
  assign range_flag = under | (|q[ZW-1:XW]);
  assign mod_flag   = ~under & (rem != '0);

  assign in_ready  = (state == IDLE);
  // out_valid is decoded from the state register, so reset drops it at once.
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register updates from the values held before the clock edge.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default comes first, so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = PREP;
      PREP: state_nxt = DIV;
      DIV:  if (div_last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, prepare, divide, then register the result on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q       <= '0;
      d         <= '0;
      under     <= 1'b0;
      rem       <= '0;
      q         <= '0;
      cnt       <= '0;
      div_last  <= 1'b0;
      x_o       <= '0;
      err_mod   <= 1'b0;
      err_range <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) z_q <= z_i;
        end
        PREP: begin
          d        <= diff[ZW-1:0];
          under    <= diff[ZW];
          rem      <= '0;
          q        <= '0;
          cnt      <= CNT_TOP;
          div_last <= 1'b0;
        end
        DIV: begin
          if (!div_last) begin
            rem    <= rem_nxt;
            q[cnt] <= trial_ge;
            if (cnt == '0) div_last <= 1'b1;
            else           cnt      <= cnt - 1'b1;
          end else begin
            err_range <= range_flag;
            err_mod   <= mod_flag;
            x_o       <= (range_flag | mod_flag) ? '0 : q[XW-1:0];
          end
        end
        DONE: ; // hold the result stable until out_ready
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_z5xp1_inverse_seq.sv
// Testbench for z5xp1_inverse_seq. When a code is driven, the expected result
// is pushed onto a scoreboard queue. Each scenario task pops the entry and
// compares it with what the decoder presents.
module tb_z5xp1_inverse_seq;

  localparam int XW = 7;
  localparam int ZW = 10;
  localparam int LAT = 12;

  typedef struct packed {
    logic [XW-1:0] x;
    logic          em;
    logic          er;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [ZW-1:0] z_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [XW-1:0] x_o;
  logic          err_mod;
  logic          err_range;

  int   tests = 0;
  int   fails = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  z5xp1_inverse_seq #(.XW(XW), .ZW(ZW), .MUL(5), .ADD(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z_i       (z_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_o       (x_o),
    .err_mod   (err_mod),
    .err_range (err_range)
  );

  // Reference model of the decoder written directly from the arithmetic
  // definition.
  function automatic res_t model(input int z);
    res_t r;
    int   v;
    int   qq;
    r = '0;
    if (z < 1) begin
      r.er = 1'b1;
    end else begin
      v    = z - 1;
      qq   = v / 5;
      r.em = (v % 5) != 0;
      r.er = qq >= 128;
      if (!r.em && !r.er) r.x = qq[XW-1:0];
    end
    return r;
  endfunction

  // Drive one code, wait for the result, stall `stall` cycles, then take it.
  // The latency is the number of clock edges from the accept edge until
  // out_valid is seen. A value of -1 means it timed out.
  task automatic run_op(input int z, input int stall, output res_t obs, output int lat);
    int guard;
    exp_q.push_back(model(z));
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    z_i       = z[ZW-1:0];
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    z_i      = ZW'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    repeat (stall) @(negedge clk);
    obs       = {x_o, err_mod, err_range};
    out_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    tests++;
    if (x_o !== '0 || err_mod !== 1'b0 || err_range !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: x=%0d em=%b er=%b, want 0/0/0", x_o, err_mod, err_range);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    res_t obs, e;
    int   lat;
    run_op(1, 0, obs, lat);
    e = exp_q.pop_front();
    tests++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL latency_z1: got %0d cycles, want %0d", lat, LAT);
    end
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL result_z1: got x=%0d em=%b er=%b, want x=%0d em=%b er=%b",
               obs.x, obs.em, obs.er, e.x, e.em, e.er);
    end
  endtask

  task automatic test_boundaries();
    int   vec[4] = '{636, 641, 0, 7};
    res_t obs, e;
    int   lat;
    foreach (vec[i]) begin
      run_op(vec[i], 1, obs, lat);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL boundary_z%0d: got x=%0d em=%b er=%b, want x=%0d em=%b er=%b",
                 vec[i], obs.x, obs.em, obs.er, e.x, e.em, e.er);
      end
    end
  endtask

  task automatic test_stall();
    res_t e, held, now_v;
    int   lat;
    res_t obs;
    exp_q.push_back(model(636));
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    z_i       = 10'd636;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e    = exp_q.pop_front();
    held = {x_o, err_mod, err_range};
    tests++;
    if (held !== e) begin
      fails++;
      $display("FAIL stall_result: got x=%0d em=%b er=%b, want x=%0d em=%b er=%b",
               held.x, held.em, held.er, e.x, e.em, e.er);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      z_i      = ZW'($urandom);
      @(negedge clk);
      now_v = {x_o, err_mod, err_range};
      tests++;
      if (now_v !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold_%0d: x=%0d em=%b er=%b ov=%b ir=%b, want x=%0d em=%b er=%b ov=1 ir=0",
                 c, now_v.x, now_v.em, now_v.er, out_valid, in_ready, e.x, e.em, e.er);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: ov=%b ir=%b, want 0/1", out_valid, in_ready);
    end
    run_op(7, 0, obs, lat);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e || lat !== LAT) begin
      fails++;
      $display("FAIL stall_next_z7: got x=%0d em=%b er=%b lat=%0d, want x=%0d em=%b er=%b lat=%0d",
               obs.x, obs.em, obs.er, lat, e.x, e.em, e.er, LAT);
    end
  endtask

  task automatic test_reset_mid();
    res_t obs, e;
    int   lat;
    bit   leaked;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    z_i       = 10'd500;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_abort: ov=%b ir=%b, want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    leaked = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaked = 1'b1;
    end
    tests++;
    if (leaked || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_no_partial: leaked=%b ir=%b, want 0/1", leaked, in_ready);
    end
    run_op(306, 2, obs, lat);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL midreset_next_z306: got x=%0d em=%b er=%b, want x=%0d em=%b er=%b",
               obs.x, obs.em, obs.er, e.x, e.em, e.er);
    end
  endtask

  task automatic test_back_to_back();
    res_t obs, e;
    int   lat;
    for (int z = 0; z < (1 << ZW); z++) begin
      run_op(z, $urandom_range(0, 3), obs, lat);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL sweep_z%0d: got x=%0d em=%b er=%b, want x=%0d em=%b er=%b",
                 z, obs.x, obs.em, obs.er, e.x, e.em, e.er);
      end
      tests++;
      if (lat !== LAT) begin
        fails++;
        $display("FAIL sweep_lat_z%0d: got %0d, want %0d", z, lat, LAT);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_boundaries();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
